// File: rtl/PixelSensorConfig.sv
// Shared pixel sensor configuration: array geometry, ramp length and the
// readout controller state encoding.
package PixelSensorConfig;

  localparam int unsigned PIXEL_ARRAY_HEIGHT = 2;
  localparam int unsigned PIXEL_ARRAY_WIDTH  = 4;
  localparam int unsigned PIXEL_BITS         = 8;
  localparam int unsigned RAMP_LEN           = 256;
  localparam int unsigned ROW_IDX_W          =
    (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam int unsigned CNT_W              = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READOUT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/pixel_array_controller.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion and
// row-by-row readout with downstream back-pressure.
module pixel_array_controller
  import PixelSensorConfig::*;
#(
  parameter int unsigned ERASE_CYCLES  = 5,
  parameter int unsigned EXPOSE_CYCLES = 255
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          START,
  input  logic                          ROW_READY,
  output logic                          ERASE,
  output logic                          EXPOSE,
  output logic                          ANALOG_RAMP,
  output logic [7:0]                    DIGITAL_RAMP,
  output logic [PIXEL_ARRAY_HEIGHT-1:0] READ,
  output logic                          ROW_VALID,
  output logic [ROW_IDX_W-1:0]          ROW_INDEX,
  output logic                          BUSY,
  output logic                          FRAME_DONE
);

  localparam logic [CNT_W-1:0]     ERASE_LAST  = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     EXPOSE_LAST = CNT_W'(EXPOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     RAMP_LAST   = CNT_W'(RAMP_LEN - 1);
  localparam logic [ROW_IDX_W-1:0] ROW_LAST    = ROW_IDX_W'(PIXEL_ARRAY_HEIGHT - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ROW_IDX_W-1:0]          row_q, row_d;
  logic                          erase_q, erase_d;
  logic                          expose_q, expose_d;
  logic                          analog_ramp_q, analog_ramp_d;
  logic [7:0]                    digital_ramp_q, digital_ramp_d;
  logic [PIXEL_ARRAY_HEIGHT-1:0] read_q, read_d;
  logic                          row_valid_q, row_valid_d;
  logic [ROW_IDX_W-1:0]          row_index_q, row_index_d;
  logic                          busy_q, busy_d;
  logic                          frame_done_q, frame_done_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      row_q          <= '0;
      erase_q        <= 1'b0;
      expose_q       <= 1'b0;
      analog_ramp_q  <= 1'b0;
      digital_ramp_q <= '0;
      read_q         <= '0;
      row_valid_q    <= 1'b0;
      row_index_q    <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      row_q          <= row_d;
      erase_q        <= erase_d;
      expose_q       <= expose_d;
      analog_ramp_q  <= analog_ramp_d;
      digital_ramp_q <= digital_ramp_d;
      read_q         <= read_d;
      row_valid_q    <= row_valid_d;
      row_index_q    <= row_index_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Next state; the phase counter restarts from 0 on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    row_d   = row_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        row_d = '0;
        if (START) state_d = ST_ERASE;
      end
      ST_ERASE: begin
        if (cnt_q == ERASE_LAST) begin
          state_d = ST_EXPOSE;
          cnt_d   = '0;
        end
      end
      ST_EXPOSE: begin
        if (cnt_q == EXPOSE_LAST) begin
          state_d = ST_CONVERT;
          cnt_d   = '0;
        end
      end
      ST_CONVERT: begin
        if (cnt_q == RAMP_LAST) begin
          state_d = ST_READOUT;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      ST_READOUT: begin
        cnt_d = '0;
        if (ROW_READY) begin
          if (row_q == ROW_LAST) state_d = ST_DONE;
          else                   row_d   = row_q + ROW_IDX_W'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        row_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        row_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the flops line up with state_q.
  always_comb begin
    erase_d        = (state_d == ST_ERASE);
    expose_d       = (state_d == ST_EXPOSE);
    analog_ramp_d  = (state_d == ST_CONVERT);
    digital_ramp_d = '0;
    read_d         = '0;
    row_valid_d    = 1'b0;
    row_index_d    = '0;
    busy_d         = (state_d != ST_IDLE);
    frame_done_d   = (state_d == ST_DONE);
    if (state_d == ST_CONVERT) digital_ramp_d = 8'(cnt_d);
    if (state_d == ST_READOUT) begin
      read_d      = PIXEL_ARRAY_HEIGHT'(1) << row_d;
      row_valid_d = 1'b1;
      row_index_d = row_d;
    end
  end

  assign ERASE        = erase_q;
  assign EXPOSE       = expose_q;
  assign ANALOG_RAMP  = analog_ramp_q;
  assign DIGITAL_RAMP = digital_ramp_q;
  assign READ         = read_q;
  assign ROW_VALID    = row_valid_q;
  assign ROW_INDEX    = row_index_q;
  assign BUSY         = busy_q;
  assign FRAME_DONE   = frame_done_q;

endmodule

// File: doc/pixel_array_controller.md
PIXEL_ARRAY_CONTROLLER -- requirements
Module: pixel_array_controller

Interface
REQ-001 Parameter SHALL be: ERASE_CYCLES, 5, cycles ERASE is held high (range 1..65535).
REQ-002 Parameter SHALL be: EXPOSE_CYCLES, 255, cycles EXPOSE is held high (range 1..65535).
REQ-003 Port SHALL be: CLK  input  1  sole clock, rising edge.
REQ-004 Port SHALL be: RESET_N  input  1  asynchronous, active-low reset.
REQ-005 Port SHALL be: START  input  1  frame request, sampled only in IDLE.
REQ-006 Port SHALL be: ROW_READY  input  1  downstream accepts the current row.
REQ-007 Port SHALL be: ERASE  output  1  pixel erase strobe to the array.
REQ-008 Port SHALL be: EXPOSE  output  1  pixel exposure enable to the array.
REQ-009 Port SHALL be: ANALOG_RAMP  output  1  comparator ramp enable to the array.
REQ-010 Port SHALL be: DIGITAL_RAMP  output  8  ramp code to the array.
REQ-011 Port SHALL be: READ  output  PIXEL_ARRAY_HEIGHT  one-hot row select to the array.
REQ-012 Port SHALL be: ROW_VALID  output  1  DATA_OUT of the array holds the selected row.
REQ-013 Port SHALL be: ROW_INDEX  output  $clog2(PIXEL_ARRAY_HEIGHT) (minimum 1)  index of the selected row.
REQ-014 Port SHALL be: BUSY  output  1  high in every state except IDLE.
REQ-015 Port SHALL be: FRAME_DONE  output  1  one-cycle pulse after the last row is accepted.

Function
REQ-016 The FSM SHALL have the states IDLE, ERASE, EXPOSE, CONVERT, READOUT and DONE, and all outputs SHALL be registered.
REQ-017 In IDLE, START=1 SHALL move the FSM to ERASE on the next edge; START SHALL be ignored in all other states.
REQ-018 ERASE SHALL be high for exactly ERASE_CYCLES cycles, then the FSM SHALL enter EXPOSE with no gap cycle.
REQ-019 EXPOSE SHALL be high for exactly EXPOSE_CYCLES cycles, then the FSM SHALL enter CONVERT with no gap cycle.
REQ-020 In CONVERT, ANALOG_RAMP SHALL be high for exactly 256 cycles while DIGITAL_RAMP steps 0,1,...,255, one step per cycle, starting at 0 in the first cycle.
REQ-021 Outside CONVERT, DIGITAL_RAMP SHALL be 0 and ANALOG_RAMP SHALL be 0.
REQ-022 READOUT SHALL start at row 0, drive READ[i]=1 with all other bits 0, set ROW_INDEX=i and hold ROW_VALID=1.
REQ-023 A row SHALL be accepted on any edge where ROW_VALID=1 and ROW_READY=1.
REQ-024 On acceptance of row i, where i is below HEIGHT-1, the next cycle SHALL select row i+1.
REQ-025 On acceptance of row HEIGHT-1, the next cycle SHALL be DONE, with READ=0 and ROW_VALID=0.
REQ-026 While ROW_READY=0, READ, ROW_INDEX and ROW_VALID SHALL hold unchanged for any number of cycles.
REQ-027 ROW_READY SHALL have no effect outside READOUT.
REQ-028 DONE SHALL last one cycle, with FRAME_DONE=1 and BUSY=1, then the FSM SHALL return to IDLE.
REQ-029 START may be high in that IDLE cycle, in which case a new frame SHALL begin on the following edge.
REQ-030 At most one of ERASE, EXPOSE, ANALOG_RAMP and READ!=0 SHALL be active in any cycle.
REQ-031 The phase counter SHALL be 16 bits wide, SHALL reset to 0 at each state entry, and SHALL never wrap within a phase.

Reset
REQ-032 Asserting RESET_N=0 SHALL immediately force the FSM to IDLE, all counters to 0, and every output to 0, including mid-phase and mid-readout.
REQ-033 After RESET_N deasserts, the block SHALL remain in IDLE until START is seen; an aborted frame SHALL NOT resume and SHALL NOT produce FRAME_DONE.

Structure
REQ-034 PIXEL_ARRAY_HEIGHT, PIXEL_ARRAY_WIDTH and PIXEL_BITS SHALL be taken from the shared PixelSensorConfig package.
REQ-035 The FSM state enum and the ramp length constant (256) SHALL be added to PixelSensorConfig.
REQ-036 The block SHALL be a single module with no sub-modules, and it SHALL drive pixel_array directly with its ports connected by name.

Verification (HEIGHT=2, ERASE_CYCLES=5, EXPOSE_CYCLES=10)
REQ-037 Reset then a one-cycle START pulse SHALL produce ERASE=1 for 5 cycles, then EXPOSE=1 for 10, then ANALOG_RAMP=1 for 256 with DIGITAL_RAMP 0..255, then READ=2'b01.
REQ-038 With ROW_READY tied to 1, READ SHALL be 01 for 1 cycle then 10 for 1 cycle, then FRAME_DONE=1 for 1 cycle, then BUSY=0; the frame SHALL total 5+10+256+2+1 = 274 busy cycles.
REQ-039 ROW_READY=0 for 7 cycles on row 0 SHALL hold READ=01 and ROW_INDEX=0 for 8 cycles, with no change to DIGITAL_RAMP.
REQ-040 START pulses during EXPOSE and during READOUT SHALL be ignored, and exactly one FRAME_DONE SHALL occur.
REQ-041 RESET_N=0 asserted at DIGITAL_RAMP=100 SHALL drive all outputs to 0 asynchronously; after release, no activity SHALL occur until START, and a full frame SHALL then complete normally.
REQ-042 START held high continuously SHALL produce back-to-back frames, with exactly one IDLE cycle between FRAME_DONE and the next ERASE.
